modexp_ctrl: RTL and testbench
==============================

MODEXP_CTRL -- requirements
Module: modexp_ctrl

Interface
REQ-001 Parameter WIDTH, default 512, operand/modulus width in bits; matches the shared montgomery core.
REQ-002 Parameter EXP_WIDTH, default 512, exponent width in bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 resetn  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  one-cycle request pulse; operands sampled in the same cycle.
REQ-006 in_x  input  WIDTH  base in Montgomery form (x·R mod m, R=2^WIDTH).
REQ-007 in_r  input  WIDTH  R mod m (Montgomery one).
REQ-008 in_m  input  WIDTH  odd modulus m.
REQ-009 in_e  input  EXP_WIDTH  exponent.
REQ-010 result  output  WIDTH  x^e mod m in normal form; valid from done until the next accepted start.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 busy  output  1  high from the cycle after an accepted start through the done cycle.
REQ-013 mont_start  output  1  one-cycle start pulse to the montgomery core.
REQ-014 mont_a, mont_b, mont_m  output  WIDTH  core operands; held stable from mont_start until mont_done.
REQ-015 mont_result  input  WIDTH  core product; valid when mont_done is high.
REQ-016 mont_done  input  1  core one-cycle completion pulse.

Function
REQ-017 Algorithm: left-to-right square-and-multiply, then one conversion multiply: A=in_r; for each scanned bit i (MSB first): A=Mont(A,A); if e[i]: A=Mont(A,X); finally result=Mont(A,1).
REQ-018 States: IDLE, SQ_GO, SQ_WAIT, MUL_GO, MUL_WAIT, FIN_GO, FIN_WAIT, DONE.
REQ-019 IDLE: start=1 -> latch in_x, in_r, in_m, in_e into internal registers; A<=in_r; bit index<=EXP_WIDTH-1; go to SQ_GO.
REQ-020 SQ_GO: mont_start=1 with mont_a=mont_b=A -> SQ_WAIT.
REQ-021 SQ_WAIT: on mont_done, A<=mont_result; if the latched e[idx]=1 -> MUL_GO; else if idx=0 -> FIN_GO; else idx--, -> SQ_GO.
REQ-022 MUL_GO: mont_start=1, mont_a=A, mont_b=X -> MUL_WAIT; on mont_done, A<=mont_result; idx=0 -> FIN_GO, else idx--, -> SQ_GO.
REQ-023 FIN_GO: mont_start=1, mont_a=A, mont_b=1 -> FIN_WAIT; on mont_done, result<=mont_result -> DONE.
REQ-024 DONE: done=1 for exactly one cycle -> IDLE.
REQ-025 mont_m equals the latched m at all times after start; mont_start is never asserted while a core operation is outstanding.
REQ-026 start while busy is ignored; the latched operands and the FSM are unaffected.
REQ-027 mont_done received in any state other than *_WAIT is ignored.
REQ-028 Latency: core invocations = squares + popcount(e) + 1; each invocation adds 1 cycle (GO) plus the core latency; 1 extra cycle in DONE.
REQ-029 e=0: result = Mont(R mod m, 1) = 1 (for m>1).

Reset
REQ-030 resetn low, any state including mid-operation -> IDLE immediately; result=0, done=0, busy=0, mont_start=0, mont_a/b/m=0, A=0, idx=0.
REQ-031 A core operation in flight at reset is abandoned; a subsequent mont_done is ignored per REQ-027.

Configuration
REQ-032 Macro MODEXP_SKIP_LEADING_ZEROS_EN defined: on start, idx is loaded with the position of the most significant 1 in in_e; if in_e=0, go directly to FIN_GO (1 core invocation).
REQ-033 Macro not defined: all EXP_WIDTH bits are scanned; the square count is always EXP_WIDTH (exponent-length-independent timing).

Verification
REQ-034 m=1000003, x=2 (in_x=2·R mod m), e=20 -> result=48573, single done pulse; 8 mont_start pulses with macro, EXP_WIDTH+3 without.
REQ-035 m=1000003, x=2, e=10 -> result=1024.
REQ-036 e=0, any odd m>1 -> result=1; 1 mont_start pulse with macro, EXP_WIDTH+1 without.
REQ-037 e=1, x=12345, m=1000003 -> result=12345.
REQ-038 start re-pulsed during SQ_WAIT with different operands -> ignored; the original result is still produced.
REQ-039 resetn pulsed low during MUL_WAIT -> all outputs 0 in the same cycle; a new start after release -> correct result.

Source files
------------

// File: rtl/modexp_ctrl.sv
// Modular exponentiation sequencer driving a shared Montgomery multiplier core.
// Optional MODEXP_SKIP_LEADING_ZEROS_EN: start scanning at the exponent's leading one.
module modexp_ctrl #(
    parameter int unsigned WIDTH     = 512,
    parameter int unsigned EXP_WIDTH = 512
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [WIDTH-1:0]     in_r,
    input  logic [WIDTH-1:0]     in_m,
    input  logic [EXP_WIDTH-1:0] in_e,
    output logic [WIDTH-1:0]     result,
    output logic                 done,
    output logic                 busy,
    output logic                 mont_start,
    output logic [WIDTH-1:0]     mont_a,
    output logic [WIDTH-1:0]     mont_b,
    output logic [WIDTH-1:0]     mont_m,
    input  logic [WIDTH-1:0]     mont_result,
    input  logic                 mont_done
);

    localparam int unsigned IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SQ_GO    = 3'd1;
    localparam logic [2:0] SQ_WAIT  = 3'd2;
    localparam logic [2:0] MUL_GO   = 3'd3;
    localparam logic [2:0] MUL_WAIT = 3'd4;
    localparam logic [2:0] FIN_GO   = 3'd5;
    localparam logic [2:0] FIN_WAIT = 3'd6;
    localparam logic [2:0] DONE     = 3'd7;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [2:0]           r_state;
    logic [WIDTH-1:0]     r_x;
    logic [WIDTH-1:0]     r_m;
    logic [EXP_WIDTH-1:0] r_e;
    logic [WIDTH-1:0]     r_a;
    logic [IW-1:0]        r_idx;
    logic [WIDTH-1:0]     r_result;

    logic [IW-1:0]        w_first_idx;
    logic [2:0]           w_first_state;

`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
    always_comb begin
        w_first_idx = '0;
        for (int unsigned i = 0; i < EXP_WIDTH; i++) begin
            if (in_e[i]) w_first_idx = IW'(i);
        end
    end
    assign w_first_state = (in_e == '0) ? FIN_GO : SQ_GO;
`else
    assign w_first_idx   = IW'(EXP_WIDTH - 1);
    assign w_first_state = SQ_GO;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_x      <= '0;
            r_m      <= '0;
            r_e      <= '0;
            r_a      <= '0;
            r_idx    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_x     <= in_x;
                        r_m     <= in_m;
                        r_e     <= in_e;
                        r_a     <= in_r;
                        r_idx   <= w_first_idx;
                        r_state <= w_first_state;
                    end
                end
                SQ_GO:  r_state <= SQ_WAIT;
                SQ_WAIT: begin
                    if (mont_done) begin
                        r_a <= mont_result;
                        if (r_e[r_idx]) begin
                            r_state <= MUL_GO;
                        end else if (r_idx == '0) begin
                            r_state <= FIN_GO;
                        end else begin
                            r_idx   <= r_idx - IW'(1);
                            r_state <= SQ_GO;
                        end
                    end
                end
                MUL_GO: r_state <= MUL_WAIT;
                MUL_WAIT: begin
                    if (mont_done) begin
                        r_a <= mont_result;
                        if (r_idx == '0) begin
                            r_state <= FIN_GO;
                        end else begin
                            r_idx   <= r_idx - IW'(1);
                            r_state <= SQ_GO;
                        end
                    end
                end
                FIN_GO: r_state <= FIN_WAIT;
                FIN_WAIT: begin
                    if (mont_done) begin
                        r_result <= mont_result;
                        r_state  <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Operands are decoded from state and r_a, which only changes on mont_done,
    // so they stay stable for the whole GO/WAIT pair.
    always_comb begin
        mont_a     = '0;
        mont_b     = '0;
        mont_start = 1'b0;
        case (r_state)
            SQ_GO, SQ_WAIT: begin
                mont_a = r_a;
                mont_b = r_a;
            end
            MUL_GO, MUL_WAIT: begin
                mont_a = r_a;
                mont_b = r_x;
            end
            FIN_GO, FIN_WAIT: begin
                mont_a = r_a;
                mont_b = ONE;
            end
            default: ;
        endcase
        if (r_state == SQ_GO || r_state == MUL_GO || r_state == FIN_GO)
            mont_start = 1'b1;
    end

    assign mont_m = r_m;
    assign result = r_result;
    assign done   = (r_state == DONE);
    assign busy   = (r_state != IDLE);

endmodule

// File: tb/tb_modexp_ctrl.sv
// Scoreboard bench for modexp_ctrl with a behavioural Montgomery core (WIDTH=32, EXP_WIDTH=16).
module tb_modexp_ctrl;

    localparam int unsigned W  = 32;
    localparam int unsigned EW = 16;
    localparam longint unsigned M1 = 64'd1000003;

    typedef struct {
        logic [W-1:0] res;
        int           starts;
    } exp_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  in_x = '0, in_r = '0, in_m = '0;
    logic [EW-1:0] in_e = '0;
    logic [W-1:0]  result, mont_a, mont_b, mont_m, mont_result;
    logic          done, busy, mont_start, mont_done;

    logic          model_done = 1'b0;
    logic          stray_done = 1'b0;
    logic [W-1:0]  core_out = '0;
    logic          core_busy = 1'b0;
    int            core_cnt = 0;
    int            n_inv = 0;
    logic [W-1:0]  lat_a = '0, lat_b = '0, lat_m = '0;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_done = 0;
    int   starts_seen = 0;

    assign mont_done   = model_done | stray_done;
    assign mont_result = stray_done ? 32'hDEADBEEF : core_out;

    modexp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .in_x(in_x), .in_r(in_r), .in_m(in_m), .in_e(in_e),
        .result(result), .done(done), .busy(busy),
        .mont_start(mont_start), .mont_a(mont_a), .mont_b(mont_b), .mont_m(mont_m),
        .mont_result(mont_result), .mont_done(mont_done)
    );

    always #5 clk = ~clk;

    // a*b*2^-W mod m, halving modulo an odd m one bit at a time
    function automatic longint unsigned mont(input longint unsigned a, input longint unsigned b,
                                             input longint unsigned m);
        longint unsigned t;
        if (m == 0) return 0;
        t = ((a % m) * (b % m)) % m;
        for (int i = 0; i < int'(W); i++)
            t = t[0] ? (t + m) >> 1 : t >> 1;
        return t;
    endfunction

    function automatic longint unsigned to_mont(input longint unsigned x, input longint unsigned m);
        return (x * ((64'd1 << W) % m)) % m;
    endfunction

    function automatic int exp_starts(input logic [EW-1:0] e);
        int pc;
        int p;
        pc = $countones(e);
        p  = 0;
        for (int i = 0; i < int'(EW); i++)
            if (e[i]) p = i;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
        if (e == '0) return 1;
        return p + 1 + pc + 1;
`else
        return int'(EW) + pc + 1 + (p - p);
`endif
    endfunction

    task automatic check(input string name, input longint unsigned act, input longint unsigned req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Montgomery core model: latency 1..3 cycles, rotating per invocation.
    always @(posedge clk) begin
        model_done <= 1'b0;
        if (mont_start) begin
            core_busy <= 1'b1;
            core_cnt  <= 1 + (n_inv % 3);
            n_inv     <= n_inv + 1;
            lat_a     <= mont_a;
            lat_b     <= mont_b;
            lat_m     <= mont_m;
            core_out  <= W'(mont(mont_a, mont_b, mont_m));
        end else if (core_busy) begin
            if (core_cnt <= 1) begin
                core_busy  <= 1'b0;
                model_done <= 1'b1;
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!resetn) begin
            starts_seen = 0;
        end else begin
            if (mont_start) begin
                starts_seen++;
                check("no_overlap", core_busy, 0);
            end
            if (core_busy && busy) begin
                check("hold_a", mont_a, lat_a);
                check("hold_b", mont_b, lat_b);
                check("hold_m", mont_m, lat_m);
            end
            if (done) begin
                n_done++;
                check("busy_at_done", busy, 1);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got done with result %0d, required no done", result);
                end else begin
                    exp_t t;
                    t = sb.pop_front();
                    check("result", result, t.res);
                    check("mont_starts", starts_seen, t.starts);
                end
                starts_seen = 0;
            end
        end
    end

    task automatic issue(input longint unsigned x, input logic [EW-1:0] e, input longint unsigned m,
                         input longint unsigned exp_res, input bit push);
        exp_t t;
        if (push) begin
            t.res    = W'(exp_res);
            t.starts = exp_starts(e);
            sb.push_back(t);
        end
        @(negedge clk);
        in_x  = W'(to_mont(x, m));
        in_r  = W'((64'd1 << W) % m);
        in_m  = W'(m);
        in_e  = e;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 2000; i++) begin
            if (n_done != d0) break;
            @(negedge clk);
        end
        if (n_done == d0) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got no done in 2000 cycles, required done");
            sb.delete();
        end
        @(negedge clk);
        check("busy_after_done", busy, 0);
    endtask

    task automatic run_op(input longint unsigned x, input logic [EW-1:0] e, input longint unsigned m,
                          input longint unsigned exp_res);
        int d0;
        d0 = n_done;
        issue(x, e, m, exp_res, 1'b1);
        wait_done(d0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_result"}, result, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_mont_start"}, mont_start, 0);
        check({tag, "_mont_a"}, mont_a, 0);
        check({tag, "_mont_b"}, mont_b, 0);
        check({tag, "_mont_m"}, mont_m, 0);
    endtask

    initial begin
        int  d0;
        bit  hit;
        longint unsigned xm;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        run_op(2, 16'd20, M1, 48573);
        run_op(2, 16'd10, M1, 1024);
        run_op(5, 16'd0, M1, 1);
        run_op(3, 16'd0, 7, 1);
        run_op(12345, 16'd1, M1, 12345);
        run_op(5, 16'd3, M1, 125);
        run_op(3, 16'd13, M1, 594320);
        run_op(1, 16'h8000, M1, 1);
        run_op(3, 16'd5, 7, 5);

        // stray core completion while idle must not disturb anything
        @(negedge clk);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        @(negedge clk);
        check("stray_result_hold", result, 5);
        check("stray_busy", busy, 0);

        // start re-pulsed during SQ_WAIT
        d0 = n_done;
        issue(2, 16'd20, M1, 48573, 1'b1);
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (mont_start) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        check("restart_saw_sq_go", hit, 1);
        @(negedge clk);
        in_x  = 32'd5;
        in_r  = 32'd1;
        in_m  = 32'd7;
        in_e  = 16'd10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(d0);

        // reset during MUL_WAIT
        xm = to_mont(2, M1);
        issue(2, 16'd20, M1, 0, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (mont_start && mont_b == W'(xm) && mont_a != mont_b) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        check("reset_saw_mul_go", hit, 1);
        @(negedge clk);
        d0 = n_done;
        resetn = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        check("no_done_after_reset", n_done, d0);
        run_op(2, 16'd10, M1, 1024);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1);
    end

endmodule
